// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

    // Fetch sequencer states; at most one memory request is ever outstanding
    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HELD  = 2'd2,
        DROP  = 2'd3
    } fetch_state_t;

    // addi x0,x0,0 -- the bubble instruction
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

    // One IF/ID pipeline entry
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } if_id_entry_t;

    // Instructions are word aligned; low address bits of a target are dropped
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// rtl/fetch_unit_if_id_reg.sv - IF/ID pipeline register with load, hold and flush
module if_id_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_load,
    input  logic        i_hold,
    input  logic        i_flush,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_pc_plus4,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4
);

    logic         r_valid;
    if_id_entry_t r_entry;

    // Priority: reset, flush, load, hold; otherwise insert a bubble.
    // Flush and bubble only kill the instruction; the pc fields keep their value.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_entry <= '{instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h0};
        end else if (i_flush) begin
            r_valid       <= 1'b0;
            r_entry.instr <= NOP_INSTR;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_entry <= '{instr: i_instr, pc: i_pc, pc_plus4: i_pc_plus4};
        end else if (!i_hold) begin
            r_valid       <= 1'b0;
            r_entry.instr <= NOP_INSTR;
        end
    end

    assign o_valid    = r_valid;
    assign o_instr    = r_entry.instr;
    assign o_pc       = r_entry.pc;
    assign o_pc_plus4 = r_entry.pc_plus4;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch sequencer with skid buffer feeding IF/ID
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [6:0]  id_opcode
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    if_id_entry_t r_skid;

    logic [31:0]  w_pc_plus4;
    logic         w_accept;
    logic         w_load;
    if_id_entry_t w_mem_entry;
    if_id_entry_t w_load_entry;

    // Address arithmetic wraps modulo 2^32 by construction
    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_mem_entry = '{instr: imem_rdata, pc: r_pc, pc_plus4: w_pc_plus4};
    assign w_accept    = (r_state == WAIT) && imem_rvalid;

    // A new entry enters IF/ID from memory directly or from the skid buffer
    assign w_load       = !redirect && !stall && (w_accept || (r_state == HELD));
    assign w_load_entry = (r_state == HELD) ? r_skid : w_mem_entry;

    // The request is suppressed in reset and on a redirect cycle
    assign imem_req  = reset_n && !redirect && (r_state == ISSUE);
    assign imem_addr = r_pc;

    // Fetch sequencer, pc register and skid buffer
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ISSUE;
            r_pc    <= RESET_PC;
            r_skid  <= '{instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h0};
        end else if (redirect) begin
            r_pc <= align_pc(redirect_pc);
            case (r_state)
                ISSUE:   r_state <= ISSUE;
                WAIT:    r_state <= imem_rvalid ? ISSUE : DROP;
                HELD:    r_state <= ISSUE;
                // A response landing on the same cycle is the one being dropped,
                // so there is nothing left outstanding to wait for.
                DROP:    r_state <= imem_rvalid ? ISSUE : DROP;
                default: r_state <= ISSUE;
            endcase
        end else begin
            case (r_state)
                // A response here has no matching request and is ignored
                ISSUE: r_state <= WAIT;
                WAIT: begin
                    if (imem_rvalid) begin
                        r_pc <= w_pc_plus4;
                        if (stall) begin
                            r_skid  <= w_mem_entry;
                            r_state <= HELD;
                        end else begin
                            r_state <= ISSUE;
                        end
                    end
                end
                HELD: begin
                    if (!stall) begin
                        r_state <= ISSUE;
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        r_state <= ISSUE;
                    end
                end
                default: r_state <= ISSUE;
            endcase
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_load),
        .i_hold     (stall),
        .i_flush    (redirect),
        .i_instr    (w_load_entry.instr),
        .i_pc       (w_load_entry.pc),
        .i_pc_plus4 (w_load_entry.pc_plus4),
        .o_valid    (id_valid),
        .o_instr    (id_instr),
        .o_pc       (id_pc),
        .o_pc_plus4 (id_pc_plus4)
    );

    assign id_opcode = id_instr[6:0];

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning: first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, meaning: addi x0,x0,0 placed in IF/ID when empty.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 stall  input  1  downstream cannot accept a new IF/ID entry this cycle.
REQ-006 redirect  input  1  taken branch/jump; flush and refetch from redirect_pc.
REQ-007 redirect_pc  input  32  redirect target.
REQ-008 imem_req  output  1  single-cycle fetch request pulse.
REQ-009 imem_addr  output  32  fetch address, valid while imem_req=1.
REQ-010 imem_rvalid  input  1  instruction memory response valid, one cycle, at least 1 cycle after imem_req.
REQ-011 imem_rdata  input  32  instruction word, valid with imem_rvalid.
REQ-012 id_valid  output  1  IF/ID holds a live instruction.
REQ-013 id_instr  output  32  IF/ID instruction.
REQ-014 id_pc / id_pc_plus4  output  32 each  address of id_instr and that address +4.
REQ-015 id_opcode  output  7  id_instr[6:0], drives the decode Controller Opcode input.

Function
REQ-016 States: ISSUE, WAIT, HELD, DROP; at most one request outstanding.
REQ-017 ISSUE: imem_req=1, imem_addr=pc; next state WAIT (unless redirect, REQ-023).
REQ-018 WAIT, imem_rvalid=1, stall=0: load IF/ID {imem_rdata, pc, pc+4}, id_valid<=1, pc<=pc+4, next ISSUE.
REQ-019 WAIT, imem_rvalid=1, stall=1: capture response into skid buffer, pc<=pc+4, next HELD; IF/ID unchanged.
REQ-020 HELD, stall=0: move skid buffer into IF/ID, id_valid<=1, next ISSUE; stall=1: remain HELD.
REQ-021 IF/ID with stall=1 and no redirect: all id_* outputs hold their values.
REQ-022 IF/ID with stall=0 and no new entry loaded: id_valid<=0, id_instr<=NOP_INSTR (bubble).
REQ-023 redirect=1 has highest priority in every state, regardless of stall: pc<={redirect_pc[31:2],2'b00}; id_valid<=0; id_instr<=NOP_INSTR.
REQ-024 Redirect next state: WAIT with imem_rvalid=0 -> DROP; WAIT with imem_rvalid=1 -> ISSUE (response discarded); HELD -> ISSUE (skid discarded); ISSUE -> ISSUE (no imem_req that cycle); DROP -> DROP.
REQ-025 DROP: on imem_rvalid discard response, next ISSUE; no IF/ID load.
REQ-026 pc increments modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-027 id_pc_plus4 is computed with the same wrap rule.
REQ-028 Fetch-to-IF/ID latency: 1 cycle issue + memory latency; with 1-cycle memory and no stall, one instruction every 2 cycles.
REQ-029 imem_rvalid in ISSUE is a protocol error; it is ignored.

Reset
REQ-030 reset_n=0 at a clock edge: pc<=RESET_PC, state<=ISSUE, id_valid<=0, id_instr<=NOP_INSTR, id_pc<=0, id_pc_plus4<=0, skid buffer cleared.
REQ-031 imem_req=0 during any cycle in which reset_n=0; first request issued in the first cycle after deassertion with imem_addr=RESET_PC.
REQ-032 Reset mid-transaction abandons the outstanding request; a late imem_rvalid arriving in ISSUE is ignored per REQ-029.
REQ-033 Reset overrides redirect and stall.

Structure
REQ-034 Shared package fetch_pkg holds the state enum (ISSUE, WAIT, HELD, DROP), NOP_INSTR, RESET_PC default, and the IF/ID entry struct {instr, pc, pc_plus4}.
REQ-035 One sub-module, if_id_reg, implements the IF/ID register with load, hold and flush controls; the FSM, pc register and skid buffer live in fetch_unit.

Verification
REQ-036 Reset then 1-cycle memory, no stall: imem_addr sequence 0x0,0x4,0x8; id_pc follows 2 cycles behind each request; id_opcode matches rdata[6:0].
REQ-037 Stall held 3 cycles while response arrives in WAIT: state HELD, id_* frozen; stall drop -> buffered instr appears next cycle, next imem_addr=pc+4.
REQ-038 Redirect to 0x0000_0103 while WAIT with no rvalid: id_valid=0 next cycle; late rvalid discarded; next imem_addr=0x0000_0100.
REQ-039 redirect and stall both asserted with id_valid=1: id_valid=0 and id_instr=0x0000_0013 next cycle.
REQ-040 pc=0xFFFF_FFFC fetched: id_pc_plus4=0x0000_0000 and next imem_addr=0x0000_0000.
REQ-041 reset_n low for one cycle during WAIT: next cycle imem_req=1, imem_addr=RESET_PC, id_valid=0.
